linear_cordic_div_ctrl: RTL
===========================

Name: linear_cordic_div_ctrl

Overview:
Iterative linear-mode CORDIC divider controller in vectoring mode. It accepts one (x, y, z0) operand set through a valid/ready handshake and computes z = z0 + y/x in Q2.14, one micro-rotation per clock. On each iteration it drives the shared linear delta-z ROM address and consumes the returned constant. It sits beside the pipelined vectoring datapath as a low-area sequencer for the linear constant ROM.

Parameters:
DATA_WIDTH, 16, width of x, y, z and delta_z (Q2.14 signed; 1.0 = 16'h4000)
ADDR_WIDTH, 4, ROM address width
ITER, 15, number of micro-rotations; ROM addresses 0..ITER-1 are used; legal range 1..2^ADDR_WIDTH

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand set valid
in_ready  output  1  block can accept operands
x_in  input  DATA_WIDTH  signed divisor
y_in  input  DATA_WIDTH  signed dividend
z_in  input  DATA_WIDTH  signed accumulator seed
rom_addr  output  ADDR_WIDTH  address to the linear delta-z ROM
delta_z  input  DATA_WIDTH  ROM data, combinational from rom_addr (2^-addr, Q2.14)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
z_out  output  DATA_WIDTH  result z0 + y/x
y_res  output  DATA_WIDTH  residual y after the final iteration
div_zero  output  1  qualifies z_out: x_in was 0

Behaviour:
- Reset (asynchronous, active-high): state IDLE; in_ready=1; out_valid=0; z_out=0; y_res=0; div_zero=0; rom_addr=0; iteration counter=0. Asserting rst mid-RUN or in DONE aborts the operation. The result is discarded and no out_valid is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at edge k, latch x, y, z and clear the counter.
  - If x_in != 0: go to RUN.
  - If x_in == 0: go to DONE with div_zero=1 and z_out = 16'h7FFF if y_in >= 0, else 16'h8000. This gives out_valid after edge k, a latency of 1.
- RUN: in_ready=0. rom_addr = counter i. On each edge:
  - d = +1 if sign(y) == sign(x), else -1. y == 0 counts as non-negative.
  - y <= y - d*(x >>> i), using an arithmetic shift.
  - z <= z + d*delta_z.
  - i <= i+1.
  - x is held constant.
  - After the edge that performs iteration ITER-1, go to DONE. Iterations run on edges k+1..k+ITER, and out_valid is high after edge k+ITER.
- Arithmetic: all adds/subtracts are DATA_WIDTH-bit two's complement and wrap silently. Convergence is guaranteed only for |y/x| < 2, and range checking is the caller's responsibility.
- DONE: out_valid=1. z_out, y_res and div_zero are stable and held until out_valid&out_ready. On that handshake, go to IDLE with out_valid=0 and in_ready=1 on the next cycle.
  - No accept occurs in the same cycle as the result handoff, so there is a minimum of one idle cycle between operations.
- rom_addr is 0 outside RUN.
- in_valid while in_ready=0 is ignored; operands are not captured.
- ITER=16 uses address 15, whose ROM value is 1 LSB, the same as address 14. The block does not special-case this.
- Throughput: one result per ITER+2 cycles when the consumer is always ready.

Test Plan:
- Basic division: x=16'h4000, y=16'h2000, z=0, out_ready=1 → out_valid exactly 15 cycles after accept; z_out=16'h2001; rom_addr steps 0..14 across the RUN cycles.
- Negative divisor: x=16'hC000, y=16'h2000, z=0 → z_out=16'hDFFF, div_zero=0.
- Divide by zero: x=0, y=16'h1000 → out_valid one cycle after accept; z_out=16'h7FFF, div_zero=1. Repeat with y=16'hF000 → z_out=16'h8000.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_valid, z_out and y_res stay constant and in_ready stays 0. Pulse a new in_valid during this window → operands not captured. Raise out_ready → IDLE next cycle.
- Reset mid-RUN: assert rst at iteration 7 → in_ready=1, out_valid=0 and rom_addr=0 immediately (asynchronous). The next operation (x=16'h4000, y=16'hE000) completes correctly, with z_out = z0 - 0.5 ± 1 LSB.
- Back-to-back: 100 random operands with |y| < |x|, comparing against a reference model of the same iteration rule → bit-exact z_out and y_res; one idle cycle between each result handoff and the next accept.

Source files
------------

// File: rtl/linear_cordic_div_ctrl.sv
// Linear-mode CORDIC divider sequencer (vectoring): z = z0 + y/x in Q2.14.
// One micro-rotation per clock. The per-iteration constant comes from an external
// delta-z ROM addressed by the iteration counter.
module linear_cordic_div_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int ITER       = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] y_in,
  input  logic [DATA_WIDTH-1:0] z_in,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] delta_z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] z_out,
  output logic [DATA_WIDTH-1:0] y_res,
  output logic                  div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ITER = ADDR_WIDTH'(ITER - 1);
  // Saturated quotient used when the divisor is zero, chosen by the sign of y.
  localparam logic [DATA_WIDTH-1:0] Z_POS_SAT = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] Z_NEG_SAT = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                        state_q, state_d;
  logic signed [DATA_WIDTH-1:0]  x_q, x_d;
  logic signed [DATA_WIDTH-1:0]  y_q, y_d;
  logic signed [DATA_WIDTH-1:0]  z_q, z_d;
  logic        [ADDR_WIDTH-1:0]  i_q, i_d;
  logic                          div_zero_q, div_zero_d;

  logic signed [DATA_WIDTH-1:0]  x_shift;
  logic                          rot_pos;

  // Rotation term and direction: drive y toward zero. y == 0 counts as non-negative.
  always_comb begin
    x_shift = x_q >>> i_q;
    rot_pos = (y_q[DATA_WIDTH-1] == x_q[DATA_WIDTH-1]);
  end

  // Next-state logic: operand capture, micro-rotation and result handoff.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    i_d        = i_q;
    div_zero_d = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d = x_in;
          y_d = y_in;
          i_d = '0;
          if (x_in == '0) begin
            // No iterations are run. The result is ready after the capture edge.
            z_d        = y_in[DATA_WIDTH-1] ? Z_NEG_SAT : Z_POS_SAT;
            div_zero_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            z_d        = z_in;
            div_zero_d = 1'b0;
            state_d    = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (rot_pos) begin
          y_d = y_q - x_shift;
          z_d = z_q + delta_z;
        end else begin
          y_d = y_q + x_shift;
          z_d = z_q - delta_z;
        end
        i_d = i_q + 1'b1;
        if (i_q == LAST_ITER) begin
          i_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      i_q        <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      i_q        <= i_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign rom_addr  = (state_q == S_RUN) ? i_q : '0;
  assign z_out     = z_q;
  assign y_res     = y_q;
  assign div_zero  = div_zero_q;

endmodule
